// File: rtl/des_key_sched_seq.sv
// Sequential DES/3DES key schedule: one C/D register pair and one PC2 network emit one
// 48-bit round subkey per accepted handshake, in encrypt or decrypt order per key.
module des_key_sched_seq #(
  parameter int unsigned NUM_KEYS     = 1,
  parameter bit          PARITY_CHECK = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [64*NUM_KEYS-1:0] KEY_IN,
  input  logic [NUM_KEYS-1:0]   DECRYPT,
  input  logic                  LOAD,
  output logic                  KEY_READY,
  output logic                  SUBKEY_VALID,
  input  logic                  SUBKEY_ACCEPT,
  output logic [47:0]           SUBKEY,
  output logic [3:0]            SUBKEY_INDEX,
  output logic [1:0]            SUBKEY_KEYSEL,
  output logic                  DONE,
  output logic                  PARITY_ERR
);

  localparam int unsigned KeyW = 64 * NUM_KEYS;

  localparam int unsigned Pc1Tab [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned Pc2Tab [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  // DES bit n of a key lives at index 64-n; bit n of C||D at index 56-n.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] cd;
    for (int i = 0; i < 56; i++) cd[55-i] = k[64-Pc1Tab[i]];
    return cd;
  endfunction

  function automatic logic [47:0] pc2(input logic [27:0] c, input logic [27:0] d);
    logic [55:0] cd;
    logic [47:0] sk;
    cd = {c, d};
    for (int i = 0; i < 48; i++) sk[47-i] = cd[56-Pc2Tab[i]];
    return sk;
  endfunction

  function automatic logic parity_ok(input logic [KeyW-1:0] k);
    logic ok;
    ok = 1'b1;
    if (PARITY_CHECK) begin
      for (int b = 0; b < 8 * NUM_KEYS; b++) begin
        if (!(^k[8*b +: 8])) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  // Round index i (0-based) uses a single-bit rotation for rounds 1, 2, 9, 16.
  function automatic logic shift_one(input logic [3:0] i);
    return (i == 4'd0) || (i == 4'd1) || (i == 4'd8) || (i == 4'd15);
  endfunction

  state_e          state_q, state_d;
  logic [KeyW-1:0] key_q, key_d, key_shift;
  logic [NUM_KEYS-1:0] dec_q, dec_d, dec_shift;
  logic [27:0]     c_q, c_d, d_q, d_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            ready_q, ready_d, valid_q, valid_d, done_q, done_d, perr_q, perr_d;
  logic [47:0]     subkey_q, subkey_d;
  logic [3:0]      idx_q, idx_d;
  logic [1:0]      ksel_q, ksel_d;

  logic            start, adv, src_dec, one_sh;
  logic [63:0]     src_key;
  logic [55:0]     cd0;

  // Pending keys are kept MSB-aligned (DECRYPT bit 0 = current key) and shifted out per key.
  assign key_shift = key_q << 64;
  assign dec_shift = dec_q >> 1;

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    dec_d    = dec_q;
    c_d      = c_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    valid_d  = valid_q;
    subkey_d = subkey_q;
    idx_d    = idx_q;
    ksel_d   = ksel_q;
    done_d   = 1'b0;
    perr_d   = 1'b0;
    start    = 1'b0;
    adv      = 1'b0;
    one_sh   = 1'b0;
    src_key  = key_shift[KeyW-1 -: 64];
    src_dec  = dec_shift[0];

    case (state_q)
      StIdle: begin
        if (LOAD) begin
          if (parity_ok(KEY_IN)) begin
            start   = 1'b1;
            src_key = KEY_IN[KeyW-1 -: 64];
            src_dec = DECRYPT[0];
            key_d   = KEY_IN;
            dec_d   = DECRYPT;
            ksel_d  = 2'd1;
            ready_d = 1'b0;
            valid_d = 1'b1;
            state_d = StEmit;
          end else begin
            perr_d = 1'b1;
          end
        end
      end
      StEmit: begin
        if (SUBKEY_ACCEPT) begin
          if (cnt_q == 4'd15) begin
            if (ksel_q == 2'(NUM_KEYS)) begin
              valid_d = 1'b0;
              ready_d = 1'b1;
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              start  = 1'b1;
              key_d  = key_shift;
              dec_d  = dec_shift;
              ksel_d = ksel_q + 2'd1;
            end
          end else begin
            adv = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    cd0 = pc1(src_key);
    if (start) begin
      cnt_d = 4'd0;
      if (src_dec) begin
        // C16/D16 equal C0/D0 after 28 total rotations.
        c_d   = cd0[55:28];
        d_d   = cd0[27:0];
        idx_d = 4'd15;
      end else begin
        c_d   = {cd0[54:28], cd0[55]};
        d_d   = {cd0[26:0], cd0[27]};
        idx_d = 4'd0;
      end
    end else if (adv) begin
      cnt_d = cnt_q + 4'd1;
      if (dec_q[0]) begin
        one_sh = shift_one(idx_q);
        c_d    = one_sh ? {c_q[0], c_q[27:1]} : {c_q[1:0], c_q[27:2]};
        d_d    = one_sh ? {d_q[0], d_q[27:1]} : {d_q[1:0], d_q[27:2]};
        idx_d  = idx_q - 4'd1;
      end else begin
        one_sh = shift_one(idx_q + 4'd1);
        c_d    = one_sh ? {c_q[26:0], c_q[27]} : {c_q[25:0], c_q[27:26]};
        d_d    = one_sh ? {d_q[26:0], d_q[27]} : {d_q[25:0], d_q[27:26]};
        idx_d  = idx_q + 4'd1;
      end
    end
    if (start || adv) subkey_d = pc2(c_d, d_d);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= StIdle;
      key_q    <= '0;
      dec_q    <= '0;
      c_q      <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      perr_q   <= 1'b0;
      subkey_q <= '0;
      idx_q    <= '0;
      ksel_q   <= 2'd1;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      dec_q    <= dec_d;
      c_q      <= c_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      perr_q   <= perr_d;
      subkey_q <= subkey_d;
      idx_q    <= idx_d;
      ksel_q   <= ksel_d;
    end
  end

  assign KEY_READY     = ready_q;
  assign SUBKEY_VALID  = valid_q;
  assign SUBKEY        = subkey_q;
  assign SUBKEY_INDEX  = idx_q;
  assign SUBKEY_KEYSEL = ksel_q;
  assign DONE          = done_q;
  assign PARITY_ERR    = perr_q;

endmodule
